lane_ctrl: RTL and testbench

LANE_CTRL -- requirements
Module: lane_ctrl

---
 rtl/lane_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_lane_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/lane_ctrl.sv
// -----------------------------------------------------------------------------
// lane_ctrl
//
// Purpose:
//    Controls one lane of objects (cars or logs) that travel across a row of
//    tiles. A programmable tick counter produces a lane step every o_Period
//    enabled clocks. On each step every object moves one tile in the lane
//    direction, wrapping at the lane edges. Level-up pulses shorten the step
//    period down to a floor. A level-reset pulse restores the initial state.
//    The block also reports whether a display query tile is occupied and
//    whether the player (frog) overlaps an object.
//
// Ports:
//    i_Clk         system clock
//    i_Rst_L       asynchronous active-low reset
//    i_Enable      motion enable; the tick counter holds while low
//    i_Level_Up    one-clock pulse, shortens the step period
//    i_Level_Reset one-clock pulse, restores period, counter and positions
//    i_Query_X/Y   display tile under test
//    i_Frog_X/Y    player tile
//    o_Hit_Query   combinational: an object occupies the query tile
//    o_Collide     registered: player overlapped an object on the last clock
//    o_Step        one-clock pulse on the cycle the lane moves
//    o_Period      current clocks-per-step
// -----------------------------------------------------------------------------
module lane_ctrl #(
   parameter int unsigned c_NUM_OBJ      = 3,
   parameter int unsigned c_MAX_X        = 14,
   parameter int unsigned c_INIT_Y       = 11,
   parameter int unsigned c_DIR          = 0,
   parameter int unsigned c_SPACING      = 5,
   parameter int unsigned c_SLOW_COUNT   = 4000000,
   parameter int unsigned c_SPEEDUP_STEP = 500000,
   parameter int unsigned c_MIN_COUNT    = 1000000
) (
   input  logic        i_Clk,
   input  logic        i_Rst_L,
   input  logic        i_Enable,
   input  logic        i_Level_Up,
   input  logic        i_Level_Reset,
   input  logic [5:0]  i_Query_X,
   input  logic [5:0]  i_Query_Y,
   input  logic [5:0]  i_Frog_X,
   input  logic [5:0]  i_Frog_Y,
   output logic        o_Hit_Query,
   output logic        o_Collide,
   output logic        o_Step,
   output logic [23:0] o_Period
);

   // Elaboration-time constants at the widths the datapath uses.
   localparam logic [5:0]  c_LAST_X   = 6'(c_MAX_X - 32'd1);
   localparam logic [6:0]  c_WIDTH_X  = 7'(c_MAX_X);
   localparam logic [5:0]  c_ROW      = 6'(c_INIT_Y);
   localparam logic [23:0] c_SLOW     = 24'(c_SLOW_COUNT);
   localparam logic [23:0] c_STEP     = 24'(c_SPEEDUP_STEP);
   localparam logic [23:0] c_FLOOR    = 24'(c_MIN_COUNT);
   // Periods at or above this value can lose a full speed-up step and still
   // stay at or above the floor; below it the result saturates to the floor.
   localparam logic [24:0] c_SAT_EDGE = 25'(c_MIN_COUNT) + 25'(c_SPEEDUP_STEP);

   // Initial tile of object k; constant-folded at elaboration.
   function automatic logic [5:0] init_pos(input int unsigned k);
      return 6'((k * c_SPACING) % c_MAX_X);
   endfunction

   // One tile of travel in the lane direction with wrap at both edges.
   function automatic logic [5:0] move_pos(input logic [5:0] p);
      logic [5:0] n;
      if (c_DIR == 32'd0) begin
         if (p >= c_LAST_X) begin
            n = 6'd0;
         end else begin
            n = p + 6'd1;
         end
      end else begin
         if (p == 6'd0) begin
            n = c_LAST_X;
         end else begin
            n = p - 6'd1;
         end
      end
      return n;
   endfunction

   logic [5:0]  pos_q [c_NUM_OBJ];
   logic [5:0]  pos_d [c_NUM_OBJ];
   logic [23:0] tick_q;
   logic [23:0] tick_d;
   logic [23:0] period_q;
   logic [23:0] period_d;
   logic        step_q;
   logic        step_d;
   logic        collide_q;
   logic        collide_d;

   logic [23:0] period_last_s;
   logic        wrap_s;
   logic [23:0] faster_s;
   logic        query_match_s;
   logic        frog_match_s;

   // Step decision and saturating speed-up value.
   always_comb begin
      period_last_s = 24'd0;
      if (period_q != 24'd0) begin
         period_last_s = period_q - 24'd1;
      end else begin
         period_last_s = 24'd0;
      end
      // ">=" rather than "==": after a speed-up the counter may already sit
      // past the new terminal count and must wrap on the next enabled clock.
      wrap_s = i_Enable && (tick_q >= period_last_s);
      if ({1'b0, period_q} >= c_SAT_EDGE) begin
         faster_s = period_q - c_STEP;
      end else begin
         faster_s = c_FLOOR;
      end
   end

   // Next-state logic for counter, period, step pulse and positions.
   always_comb begin
      tick_d   = tick_q;
      period_d = period_q;
      step_d   = 1'b0;
      for (int unsigned k = 0; k < c_NUM_OBJ; k++) begin
         pos_d[k] = pos_q[k];
      end

      if (i_Level_Reset) begin
         // Level reset overrides both a pending step and a level-up.
         tick_d   = 24'd0;
         period_d = c_SLOW;
         step_d   = 1'b0;
         for (int unsigned k = 0; k < c_NUM_OBJ; k++) begin
            pos_d[k] = init_pos(k);
         end
      end else begin
         if (wrap_s) begin
            tick_d = 24'd0;
            step_d = 1'b1;
            for (int unsigned k = 0; k < c_NUM_OBJ; k++) begin
               pos_d[k] = move_pos(pos_q[k]);
            end
         end else if (i_Enable) begin
            tick_d = tick_q + 24'd1;
         end else begin
            tick_d = tick_q;
         end

         if (i_Level_Up) begin
            period_d = faster_s;
         end else begin
            period_d = period_q;
         end
      end
   end

   // Occupancy matches for the query tile and the player tile.
   always_comb begin
      query_match_s = 1'b0;
      frog_match_s  = 1'b0;
      for (int unsigned k = 0; k < c_NUM_OBJ; k++) begin
         query_match_s = query_match_s | (pos_q[k] == i_Query_X);
         frog_match_s  = frog_match_s  | (pos_q[k] == i_Frog_X);
      end
      collide_d = (i_Frog_Y == c_ROW) && frog_match_s;
   end

   // Lane state registers; reset restores the initial layout immediately.
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         tick_q    <= 24'd0;
         period_q  <= c_SLOW;
         step_q    <= 1'b0;
         collide_q <= 1'b0;
         for (int unsigned k = 0; k < c_NUM_OBJ; k++) begin
            pos_q[k] <= init_pos(k);
         end
      end else begin
         tick_q    <= tick_d;
         period_q  <= period_d;
         step_q    <= step_d;
         collide_q <= collide_d;
         for (int unsigned k = 0; k < c_NUM_OBJ; k++) begin
            pos_q[k] <= pos_d[k];
         end
      end
   end

   // Query lookup is combinational so the display can scan tiles directly;
   // the explicit range check keeps out-of-lane columns dark.
   assign o_Hit_Query = (i_Query_Y == c_ROW) &&
                        ({1'b0, i_Query_X} < c_WIDTH_X) &&
                        query_match_s;
   assign o_Collide   = collide_q;
   assign o_Step      = step_q;
   assign o_Period    = period_q;

endmodule

// File: tb/tb_lane_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lane_ctrl
//
// Directed bench for lane_ctrl with a short period (4 clocks, floor 2).
// Instance a travels rightward, instance b leftward; both share inputs.
// Object positions are read out by scanning the query port across the lane
// and collecting o_Hit_Query into a 14-bit occupancy mask.
// Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_lane_ctrl;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic        lvl_up;
   logic        lvl_rst;
   logic [5:0]  qx;
   logic [5:0]  qy;
   logic [5:0]  fx;
   logic [5:0]  fy;

   logic        hit_a;
   logic        col_a;
   logic        step_a;
   logic [23:0] per_a;
   logic        hit_b;
   logic        col_b;
   logic        step_b;
   logic [23:0] per_b;

   int n_chk  = 0;
   int n_pass = 0;

   logic [13:0] ma;
   logic [13:0] mb;
   logic        seen;

   lane_ctrl #(
      .c_NUM_OBJ(3), .c_MAX_X(14), .c_INIT_Y(11), .c_DIR(0), .c_SPACING(5),
      .c_SLOW_COUNT(4), .c_SPEEDUP_STEP(1), .c_MIN_COUNT(2)
   ) u_dut_a (
      .i_Clk(clk), .i_Rst_L(rst_n), .i_Enable(en), .i_Level_Up(lvl_up),
      .i_Level_Reset(lvl_rst), .i_Query_X(qx), .i_Query_Y(qy),
      .i_Frog_X(fx), .i_Frog_Y(fy), .o_Hit_Query(hit_a), .o_Collide(col_a),
      .o_Step(step_a), .o_Period(per_a)
   );

   lane_ctrl #(
      .c_NUM_OBJ(3), .c_MAX_X(14), .c_INIT_Y(11), .c_DIR(1), .c_SPACING(5),
      .c_SLOW_COUNT(4), .c_SPEEDUP_STEP(1), .c_MIN_COUNT(2)
   ) u_dut_b (
      .i_Clk(clk), .i_Rst_L(rst_n), .i_Enable(en), .i_Level_Up(lvl_up),
      .i_Level_Reset(lvl_rst), .i_Query_X(qx), .i_Query_Y(qy),
      .i_Frog_X(fx), .i_Frog_Y(fy), .o_Hit_Query(hit_b), .o_Collide(col_b),
      .o_Step(step_b), .o_Period(per_b)
   );

   // 100 ns clock period.
   initial clk = 1'b0;
   always #50 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Occupancy masks of both lanes, read through the query port.
   task automatic scan(output logic [13:0] m_a, output logic [13:0] m_b);
      qy = 6'd11;
      for (int x = 0; x < 14; x++) begin
         qx = 6'(x);
         #1;
         m_a[x] = hit_a;
         m_b[x] = hit_b;
      end
   endtask

   task automatic edges(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b1; lvl_up = 1'b0; lvl_rst = 1'b0;
      fx = 6'd5; fy = 6'd11; qx = 6'd0; qy = 6'd0;
      edges(2);

      // Reset state: positions {0,5,10} in both directions.
      chk("rst_period", 32'(per_a), 32'd4);
      chk("rst_step", 32'(step_a), 32'd0);
      chk("rst_collide", 32'(col_a), 32'd0);
      scan(ma, mb);
      chk("rst_pos", 32'(ma), 32'h0421);
      chk("rst_pos_dir1", 32'(mb), 32'h0421);

      // Release; frog on (5,11) collides one clock later.
      rst_n = 1'b1;
      edges(1);
      chk("collide_on", 32'(col_a), 32'd1);
      chk("step_e1", 32'(step_a), 32'd0);
      qx = 6'd10; qy = 6'd11; #1;
      chk("hit_10_11", 32'(hit_a), 32'd1);
      qx = 6'd14; #1;
      chk("hit_14_11", 32'(hit_a), 32'd0);
      qx = 6'd10; qy = 6'd10; #1;
      chk("hit_10_10", 32'(hit_a), 32'd0);
      fy = 6'd10;
      edges(1);
      chk("collide_off", 32'(col_a), 32'd0);
      edges(1);
      chk("step_e3", 32'(step_a), 32'd0);
      edges(1);
      chk("step_e4", 32'(step_a), 32'd1);
      scan(ma, mb);
      chk("pos_step1", 32'(ma), 32'h0842);        // {1,6,11}
      chk("pos_step1_dir1", 32'(mb), 32'h2210);   // {13,4,9}
      edges(1);
      chk("step_e5", 32'(step_a), 32'd0);

      // Three more steps: object 2 wraps 13 -> 0.
      edges(11);
      chk("step_e16", 32'(step_a), 32'd1);
      scan(ma, mb);
      chk("pos_wrap", 32'(ma), 32'h0211);         // {4,9,0}
      edges(1);

      // Freeze mid-count (counter at 1) for 10 clocks.
      en = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         edges(1);
         seen = seen | step_a;
      end
      chk("frozen_step", 32'(seen), 32'd0);
      scan(ma, mb);
      chk("frozen_pos", 32'(ma), 32'h0211);
      en = 1'b1;
      edges(2);
      chk("resume_step0", 32'(step_a), 32'd0);
      edges(1);
      chk("resume_step1", 32'(step_a), 32'd1);
      scan(ma, mb);
      chk("resume_pos", 32'(ma), 32'h0422);       // {5,10,1}

      // Speed-ups: 4 -> 3 -> 2 -> 2; counter is left running.
      lvl_up = 1'b1; edges(1); lvl_up = 1'b0;
      chk("period_3", 32'(per_a), 32'd3);
      chk("up1_step", 32'(step_a), 32'd0);
      lvl_up = 1'b1; edges(1); lvl_up = 1'b0;
      chk("period_2", 32'(per_a), 32'd2);
      chk("up2_step", 32'(step_a), 32'd0);
      lvl_up = 1'b1; edges(1); lvl_up = 1'b0;
      chk("period_sat", 32'(per_a), 32'd2);
      chk("late_wrap", 32'(step_a), 32'd1);
      scan(ma, mb);
      chk("pos_late_wrap", 32'(ma), 32'h0844);    // {6,11,2}
      edges(1);
      chk("fast_step0", 32'(step_a), 32'd0);
      edges(1);
      chk("fast_step1", 32'(step_a), 32'd1);
      scan(ma, mb);
      chk("pos_fast", 32'(ma), 32'h1088);         // {7,12,3}
      edges(1);

      // Level reset with level-up on what would be a step cycle.
      lvl_up = 1'b1; lvl_rst = 1'b1;
      edges(1);
      lvl_up = 1'b0; lvl_rst = 1'b0;
      chk("lrst_period", 32'(per_a), 32'd4);
      chk("lrst_step", 32'(step_a), 32'd0);
      scan(ma, mb);
      chk("lrst_pos", 32'(ma), 32'h0421);
      edges(3);
      chk("lrst_cnt_step0", 32'(step_a), 32'd0);
      fx = 6'd0; fy = 6'd11;
      edges(1);
      chk("lrst_cnt_step1", 32'(step_a), 32'd1);
      chk("collide_x0", 32'(col_a), 32'd1);

      // Asynchronous reset right on a step/collide cycle.
      rst_n = 1'b0;
      #1;
      chk("arst_step", 32'(step_a), 32'd0);
      chk("arst_collide", 32'(col_a), 32'd0);
      scan(ma, mb);
      chk("arst_pos", 32'(ma), 32'h0421);
      edges(1);
      rst_n = 1'b1;
      edges(3);
      chk("post_rst_step0", 32'(step_a), 32'd0);
      edges(1);
      chk("post_rst_step1", 32'(step_a), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
